// File: rtl/midi_receiver_pkg.sv
// Shared MIDI definitions: status constants, parser/UART state types, helpers.
package midi_receiver_pkg;

    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
    localparam logic [7:0] MIDI_SYSTEM   = 8'hF0;
    localparam logic [7:0] MIDI_REALTIME = 8'hF8;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        NO_STATUS,
        WAIT_D1,
        WAIT_D2
    } parser_state_t;

    // Realtime bytes may interleave anywhere and never disturb the parser.
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= MIDI_REALTIME;
    endfunction

    // Program change / channel pressure carry a single data byte.
    function automatic logic is_one_data_byte(input logic [7:0] status);
        return status[7:5] == 3'b110;
    endfunction

endpackage

// File: rtl/midi_receiver_uart_rx.sv
// 8N1 UART receiver with input synchronizer, mid-bit sampling and glitch rejection.
module uart_rx
    import midi_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_error
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          strobe_q, strobe_d;
    logic          ferr_q, ferr_d;

    // Next-state logic: synchronizer shift and bit-timing state machine.
    always_comb begin
        sync1_d  = rx;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            UART_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!sync2_q) state_d = UART_START;
            end
            UART_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? UART_IDLE : UART_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UART_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = UART_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UART_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                    if (sync2_q) strobe_d = 1'b1;
                    else         ferr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; line flops reset to idle-high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= UART_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
        end
    end

    assign rx_byte     = shift_q;
    assign byte_strobe = strobe_q;
    assign frame_error = ferr_q;

endmodule

// File: rtl/midi_receiver.sv
// Monophonic MIDI note receiver: UART front end plus running-status parser.
module midi_receiver
    import midi_receiver_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 31250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_rx,
    output logic [7:0] midi_data,
    output logic       midi_valid,
    output logic [6:0] velocity,
    output logic       frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic [7:0] rx_byte;
    logic       byte_strobe;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (midi_rx),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .frame_error (frame_error)
    );

    parser_state_t pstate_q, pstate_d;
    logic [7:0]    status_q, status_d;
    logic [6:0]    data1_q, data1_d;
    logic [6:0]    note_q, note_d;
    logic [6:0]    vel_q, vel_d;
    logic          valid_q, valid_d;

    // Parser: classify each received byte and apply completed note messages.
    always_comb begin
        pstate_d = pstate_q;
        status_d = status_q;
        data1_d  = data1_q;
        note_d   = note_q;
        vel_d    = vel_q;
        valid_d  = valid_q;
        if (byte_strobe) begin
            if (is_realtime(rx_byte)) begin
                pstate_d = pstate_q;
            end else if (rx_byte >= MIDI_SYSTEM) begin
                status_d = '0;
                pstate_d = NO_STATUS;
            end else if (rx_byte[7]) begin
                status_d = rx_byte;
                pstate_d = WAIT_D1;
            end else begin
                case (pstate_q)
                    WAIT_D1: begin
                        if (!is_one_data_byte(status_q)) begin
                            data1_d  = rx_byte[6:0];
                            pstate_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        pstate_d = WAIT_D1;
                        if (status_q[7:4] == MIDI_NOTE_ON[7:4] && rx_byte[6:0] != 7'd0) begin
                            note_d  = data1_q;
                            vel_d   = rx_byte[6:0];
                            valid_d = 1'b1;
                        end else if (status_q[7:4] == MIDI_NOTE_OFF[7:4] ||
                                     status_q[7:4] == MIDI_NOTE_ON[7:4]) begin
                            if (data1_q == note_q) valid_d = 1'b0;
                        end
                    end
                    default: pstate_d = pstate_q;
                endcase
            end
        end
    end

    // Parser and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pstate_q <= NO_STATUS;
            status_q <= '0;
            data1_q  <= '0;
            note_q   <= '0;
            vel_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            status_q <= status_d;
            data1_q  <= data1_d;
            note_q   <= note_d;
            vel_q    <= vel_d;
            valid_q  <= valid_d;
        end
    end

    assign midi_data  = {1'b0, note_q};
    assign velocity   = vel_q;
    assign midi_valid = valid_q;

endmodule

// File: tb/tb_midi_receiver.sv
// Directed bench for midi_receiver: drives bit-accurate MIDI frames and checks outputs.
module tb_midi_receiver;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 31250;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       midi_rx;
    logic [7:0] midi_data;
    logic       midi_valid;
    logic [6:0] velocity;
    logic       frame_error;

    int n_assert = 0;
    int n_fail   = 0;
    int fe_cycles = 0;
    int fe_base;

    midi_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .midi_rx     (midi_rx),
        .midi_data   (midi_data),
        .midi_valid  (midi_valid),
        .velocity    (velocity),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_error === 1'b1) fe_cycles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [6:0] v, input logic g);
        chk({tag, ".midi_data"},  {24'd0, midi_data}, {24'd0, d});
        chk({tag, ".velocity"},   {25'd0, velocity},  {25'd0, v});
        chk({tag, ".midi_valid"}, {31'd0, midi_valid}, {31'd0, g});
    endtask

    task automatic bit_wait();
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit plus eight data bits, LSB first; leaves the line at bit 7.
    task automatic send_bits(input logic [7:0] b);
        midi_rx = 1'b0;
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            bit_wait();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b);
        midi_rx = 1'b1;
        bit_wait();
    endtask

    initial begin
        logic [7:0] partial;
        rst_n   = 1'b0;
        midi_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("reset", 8'h00, 7'h00, 1'b0);
        chk("reset.frame_error", {31'd0, frame_error}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Note-on with exact output latency around the final stop sample.
        send_byte(8'h90);
        send_byte(8'h3C);
        send_bits(8'h64);
        midi_rx = 1'b1;
        repeat (HALF + 3) @(posedge clk);
        #1 chk("latency.before", {31'd0, midi_valid}, 32'd0);
        @(posedge clk);
        #1 chk_out("note_on_3c", 8'h3C, 7'h64, 1'b1);
        bit_wait();

        // Running status note-on, non-matching note-off, matching note-off.
        send_byte(8'h3E);
        send_byte(8'h50);
        chk_out("running_3e", 8'h3E, 7'h50, 1'b1);
        send_byte(8'h80);
        send_byte(8'h3C);
        send_byte(8'h00);
        chk_out("off_nomatch", 8'h3E, 7'h50, 1'b1);
        send_byte(8'h3E);
        send_byte(8'h00);
        chk_out("off_running", 8'h3E, 7'h50, 1'b0);

        // Velocity-zero note-on as note-off, then again with realtime interleaved.
        send_byte(8'h90);
        send_byte(8'h40);
        send_byte(8'h7F);
        chk_out("on_40", 8'h40, 7'h7F, 1'b1);
        send_byte(8'h90);
        send_byte(8'h40);
        send_byte(8'h00);
        chk_out("vel0_off", 8'h40, 7'h7F, 1'b0);
        send_byte(8'h90);
        send_byte(8'h40);
        send_byte(8'hF8);
        send_byte(8'h7F);
        chk_out("on_40_rt", 8'h40, 7'h7F, 1'b1);
        send_byte(8'h40);
        send_byte(8'h00);
        chk_out("vel0_off_rt", 8'h40, 7'h7F, 1'b0);

        // Bad stop bit: one-cycle error, byte 0x55 must not enter the parser.
        fe_base = fe_cycles;
        send_bits(8'h55);
        midi_rx = 1'b0;
        repeat (CPB * 3 / 4) @(negedge clk);
        midi_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("frame_error.cycles", fe_cycles - fe_base, 32'd1);
        chk_out("after_bad_frame", 8'h40, 7'h7F, 1'b0);

        // Short low glitch on idle line: no byte, no error.
        fe_base = fe_cycles;
        midi_rx = 1'b0;
        repeat (4) @(negedge clk);
        midi_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch.frame_error", fe_cycles - fe_base, 32'd0);
        send_byte(8'h41);
        send_byte(8'h22);
        chk_out("on_41_after_discard", 8'h41, 7'h22, 1'b1);

        // System status clears running status; following data is ignored.
        send_byte(8'hF0);
        send_byte(8'h41);
        send_byte(8'h00);
        chk_out("sysex_ignores_data", 8'h41, 7'h22, 1'b1);

        // Reset during bit 4 of a note byte.
        send_byte(8'h90);
        partial = 8'h3C;
        midi_rx = 1'b0;
        bit_wait();
        for (int i = 0; i < 4; i++) begin
            midi_rx = partial[i];
            bit_wait();
        end
        midi_rx = partial[4];
        repeat (CPB / 3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 chk_out("mid_frame_reset", 8'h00, 7'h00, 1'b0);
        chk("mid_frame_reset.frame_error", {31'd0, frame_error}, 32'd0);
        midi_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        bit_wait();
        send_byte(8'h90);
        send_byte(8'h45);
        send_byte(8'h10);
        chk_out("on_45_after_reset", 8'h45, 7'h10, 1'b1);

        // One-data-byte message is consumed without output effect.
        send_byte(8'hC5);
        send_byte(8'h10);
        send_byte(8'h45);
        chk_out("program_change", 8'h45, 7'h10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
